// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder cell plus a carry flop computes
// {cout,sum} = a + b + cin over WIDTH cycles, LSB first.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic [WIDTH-1:0]   res_sr_q, res_sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_sr_d = res_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + CNT_W'(1);
        // The last sum bit is still in flight, so publish from the shift-in value.
        if (cnt_q == LAST_BIT) begin
          sum_d   = {fa_sum, res_sr_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_sr_q <= res_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed scenarios plus
// random operands, with a scoreboard queue of expected {cout,sum}.

module tb_serial_adder;
  localparam int WIDTH = 8;

  typedef struct packed {
    logic             c;
    logic [WIDTH-1:0] s;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_i = '0;
  logic [WIDTH-1:0] b_i = '0;
  logic             cin_i = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a_i),
    .b     (b_i),
    .cin   (cin_i),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic c);
    logic [WIDTH:0] r;
    r = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
    return '{c: r[WIDTH], s: r[WIDTH-1:0]};
  endfunction

  task automatic pop_compare(input string tag);
    exp_t e;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, 64'(sum), 64'(e.s));
      check({tag, "_cout"}, 64'(cout), 64'(e.c));
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((busy || done) && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("idle_wait", 64'({busy, done}), 64'(0));
  endtask

  // One operation: accept, then watch every cycle until done (bounded).
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic tc, input bit disturb, input bit quiet);
    int               busy_cnt;
    bit               got;
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;
    wait_idle();
    held_sum  = sum;
    held_cout = cout;
    a_i = ta; b_i = tb_v; cin_i = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sb.push_back(model(ta, tb_v, tc));
    a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); cin_i = 1'($urandom_range(0, 1));
    check("busy_after_accept", 64'(busy), 64'(1));
    busy_cnt = busy ? 1 : 0;
    got = 1'b0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_done_excl", 64'(busy & done), 64'(0));
      if (done) begin
        got = 1'b1;
        check("latency", 64'(k), 64'(WIDTH));
        pop_compare("result");
      end else begin
        if (!quiet || k == 4) begin
          check("sum_hold", 64'(sum), 64'(held_sum));
          check("cout_hold", 64'(cout), 64'(held_cout));
        end
        if (busy) busy_cnt++;
        if (disturb && (k == 3 || k == 5)) begin
          start = 1'b1;
          a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); cin_i = ~cin_i;
        end
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 64'(done), 64'(1));
    check("busy_cycles", 64'(busy_cnt), 64'(WIDTH));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_cout", 64'(cout), 64'(0));
    #1 rst_n = 1'b1;

    // Directed operations
    run_op(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);

    // start and operand changes during RUN are ignored
    run_op(8'h3C, 8'h99, 1'b1, 1'b1, 1'b0);

    // Reset mid-RUN aborts; sum currently holds a nonzero value
    wait_idle();
    check("pre_abort_sum_nonzero", 64'(sum != 0), 64'(1));
    a_i = 8'h12; b_i = 8'h34; cin_i = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    check("abort_sum", 64'(sum), 64'(0));
    check("abort_cout", 64'(cout), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_done", 64'(done), 64'(0));
    end
    #2 rst_n = 1'b1;
    run_op(8'hC8, 8'h64, 1'b1, 1'b0, 1'b0);

    // start held high for 30 cycles: accepts at offsets 0,10,20
    wait_idle();
    a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); cin_i = 1'($urandom_range(0, 1));
    start = 1'b1;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if ((e - 1) % 10 == 0) sb.push_back(model(a_i, b_i, cin_i));
      check("cont_done_period", 64'(done), 64'((e - 1) % 10 == 8));
      check("cont_busy_period", 64'(busy), 64'((e - 1) % 10 < 8));
      if (done) pop_compare("cont");
      a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); cin_i = 1'($urandom_range(0, 1));
      if (e == 30) start = 1'b0;
    end
    check("cont_sb_drained", 64'(sb.size()), 64'(0));

    // Random operands
    for (int i = 0; i < 1000; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    end
    check("final_sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
